// File: rtl/ecc_point_ctrl_if.sv
// Request/response bus between the point-addition sequencer and the GFAU.
// The master drives one field operation at a time; the slave answers with gf_done.
interface ecc_point_ctrl_if #(
  parameter int SIZE = 32
) ();
  logic [SIZE-1:0] gf_in_0;
  logic [SIZE-1:0] gf_in_1;
  logic [1:0]      gf_op;
  logic            gf_start;
  logic [SIZE-1:0] gf_result;
  logic            gf_done;

  modport master (output gf_in_0, gf_in_1, gf_op, gf_start, input gf_result, gf_done);
  modport slave  (input gf_in_0, gf_in_1, gf_op, gf_start, output gf_result, gf_done);
endinterface

// File: rtl/ecc_point_ctrl.sv
// Affine point-addition sequencer over GF(p): classifies P/Q, then walks a fixed
// micro-program of GFAU operations to produce R = P + Q.
module ecc_point_ctrl #(
  parameter int SIZE = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [SIZE-1:0] i_x1,
  input  logic [SIZE-1:0] i_y1,
  input  logic [SIZE-1:0] i_x2,
  input  logic [SIZE-1:0] i_y2,
  input  logic            i_inf1,
  input  logic            i_inf2,
  input  logic [SIZE-1:0] i_a,
  output logic            o_busy,
  output logic            o_done,
  output logic [SIZE-1:0] o_x3,
  output logic [SIZE-1:0] o_y3,
  output logic            o_inf3,
  ecc_point_ctrl_if.master gf
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_FIN} state_t;

  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

  localparam logic [3:0] R_X1 = 4'd0, R_Y1 = 4'd1, R_X2 = 4'd2, R_Y2 = 4'd3, R_A = 4'd4,
                         R_T0 = 4'd5, R_T1 = 4'd6, R_T2 = 4'd7, R_T3 = 4'd8,
                         R_LAM = 4'd9, R_X3 = 4'd10, R_Y3 = 4'd11;

  localparam logic [3:0] STEP_DBL = 4'd0, STEP_ADD = 4'd6, STEP_LAST = 4'd14;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] dst;
  } step_t;

  function automatic step_t prog(input logic [3:0] s);
    case (s)
      4'd0:    prog = '{OP_MUL, R_X1,  R_X1,  R_T0};
      4'd1:    prog = '{OP_ADD, R_T0,  R_T0,  R_T1};
      4'd2:    prog = '{OP_ADD, R_T1,  R_T0,  R_T0};
      4'd3:    prog = '{OP_ADD, R_T0,  R_A,   R_T0};
      4'd4:    prog = '{OP_ADD, R_Y1,  R_Y1,  R_T1};
      4'd5:    prog = '{OP_DIV, R_T0,  R_T1,  R_LAM};
      4'd6:    prog = '{OP_SUB, R_Y2,  R_Y1,  R_T0};
      4'd7:    prog = '{OP_SUB, R_X2,  R_X1,  R_T1};
      4'd8:    prog = '{OP_DIV, R_T0,  R_T1,  R_LAM};
      4'd9:    prog = '{OP_MUL, R_LAM, R_LAM, R_T2};
      4'd10:   prog = '{OP_SUB, R_T2,  R_X1,  R_T2};
      4'd11:   prog = '{OP_SUB, R_T2,  R_X2,  R_X3};
      4'd12:   prog = '{OP_SUB, R_X1,  R_X3,  R_T3};
      4'd13:   prog = '{OP_MUL, R_LAM, R_T3,  R_T3};
      4'd14:   prog = '{OP_SUB, R_T3,  R_Y1,  R_Y3};
      default: prog = '{OP_ADD, R_X1,  R_X1,  R_T0};
    endcase
  endfunction

  state_t          state;
  logic [3:0]      step;
  logic [3:0]      dst_r;
  logic            inf1, inf2;
  logic [SIZE-1:0] rf   [12];
  logic [SIZE-1:0] rf_n [12];

  logic            capture, special, x_eq, do_launch;
  logic [3:0]      ln_step;
  step_t           ln;
  logic [SIZE-1:0] ln_in0, ln_in1;

  // rf_n forwards the result being captured this cycle so the next step's
  // operands can be registered without a bubble.
  always_comb begin
    capture = (state == S_WAIT) && gf.gf_done;
    rf_n    = rf;
    if (capture) rf_n[dst_r] = gf.gf_result;
    x_eq    = (rf[R_X1] == rf[R_X2]);
    special = inf1 || inf2 ||
              (x_eq && ((rf[R_Y1] != rf[R_Y2]) || (rf[R_Y1] == '0)));
    if (state == S_CHECK) ln_step = x_eq ? STEP_DBL : STEP_ADD;
    else                  ln_step = (step == 4'd5) ? 4'd9 : step + 4'd1;
    ln        = prog(ln_step);
    ln_in0    = rf_n[ln.s0];
    ln_in1    = rf_n[ln.s1];
    do_launch = ((state == S_CHECK) && !special) || (capture && (step != STEP_LAST));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      step        <= '0;
      dst_r       <= '0;
      inf1        <= 1'b0;
      inf2        <= 1'b0;
      for (int i = 0; i < 12; i++) rf[i] <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_x3        <= '0;
      o_y3        <= '0;
      o_inf3      <= 1'b0;
      gf.gf_start <= 1'b0;
      gf.gf_op    <= '0;
      gf.gf_in_0  <= '0;
      gf.gf_in_1  <= '0;
    end else begin
      gf.gf_start <= 1'b0;
      o_done      <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          rf[R_X1] <= i_x1;
          rf[R_Y1] <= i_y1;
          rf[R_X2] <= i_x2;
          rf[R_Y2] <= i_y2;
          rf[R_A]  <= i_a;
          inf1     <= i_inf1;
          inf2     <= i_inf2;
          o_busy   <= 1'b1;
          state    <= S_CHECK;
        end
        S_CHECK: if (special) begin
          o_done <= 1'b1;
          state  <= S_FIN;
          if (inf1) begin
            o_x3   <= rf[R_X2];
            o_y3   <= rf[R_Y2];
            o_inf3 <= inf2;
          end else if (inf2) begin
            o_x3   <= rf[R_X1];
            o_y3   <= rf[R_Y1];
            o_inf3 <= 1'b0;
          end else begin
            o_x3   <= '0;
            o_y3   <= '0;
            o_inf3 <= 1'b1;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: if (capture) begin
          rf[dst_r] <= gf.gf_result;
          if (step == STEP_LAST) begin
            o_x3   <= rf_n[R_X3];
            o_y3   <= rf_n[R_Y3];
            o_inf3 <= 1'b0;
            o_done <= 1'b1;
            state  <= S_FIN;
          end
        end
        S_FIN: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (do_launch) begin
        step        <= ln_step;
        dst_r       <= ln.dst;
        gf.gf_op    <= ln.op;
        gf.gf_in_0  <= ln_in0;
        gf.gf_in_1  <= ln_in1;
        gf.gf_start <= 1'b1;
        state       <= S_ISSUE;
      end
    end
  end

endmodule

// File: tb/tb_ecc_point_ctrl.sv
// Scoreboard bench for ecc_point_ctrl over p = 17 with a behavioural GFAU of
// programmable latency; expectations come from textbook affine point formulas.
module tb_ecc_point_ctrl;
  localparam int     SIZE = 32;
  localparam longint P    = 17;

  logic            i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0;
  logic [SIZE-1:0] i_x1 = '0, i_y1 = '0, i_x2 = '0, i_y2 = '0, i_a = '0;
  logic            i_inf1 = 1'b0, i_inf2 = 1'b0;
  logic            o_busy, o_done, o_inf3;
  logic [SIZE-1:0] o_x3, o_y3;

  ecc_point_ctrl_if #(.SIZE(SIZE)) gf ();

  ecc_point_ctrl #(.SIZE(SIZE)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_x1(i_x1), .i_y1(i_y1), .i_x2(i_x2), .i_y2(i_y2),
    .i_inf1(i_inf1), .i_inf2(i_inf2), .i_a(i_a),
    .o_busy(o_busy), .o_done(o_done), .o_x3(o_x3), .o_y3(o_y3), .o_inf3(o_inf3),
    .gf(gf)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---- field arithmetic mod 17 ----
  function automatic longint mred(input longint v);
    return ((v % P) + P) % P;
  endfunction

  function automatic longint minv(input longint b);
    longint r = 1, base = mred(b), e = P - 2;
    while (e > 0) begin
      if (e[0]) r = mred(r * base);
      base = mred(base * base);
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] gfop(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint la = longint'(a), lb = longint'(b);
    case (op)
      2'd0:    return 32'(mred(la + lb));
      2'd1:    return 32'(mred(la - lb));
      2'd2:    return 32'(mred(la * lb));
      default: return 32'(mred(la * minv(lb)));
    endcase
  endfunction

  int lat_md = 1, lat_as = 1;
  function automatic int lat_of(input int op);
    return (op >= 2) ? lat_md : lat_as;
  endfunction

  // ---- behavioural GFAU ----
  logic        m_done, m_pend, inj_done = 1'b0, inj_en = 1'b0;
  logic [31:0] m_res, m_hold;
  int          m_cnt;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_done <= 1'b0; m_pend <= 1'b0; m_cnt <= 0; m_res <= '0; m_hold <= '0;
    end else begin
      m_done <= 1'b0;
      if (gf.gf_start) begin
        if (lat_of(int'(gf.gf_op)) <= 1) begin
          m_done <= 1'b1;
          m_res  <= gfop(gf.gf_op, gf.gf_in_0, gf.gf_in_1);
        end else begin
          m_pend <= 1'b1;
          m_cnt  <= lat_of(int'(gf.gf_op)) - 1;
          m_hold <= gfop(gf.gf_op, gf.gf_in_0, gf.gf_in_1);
        end
      end else if (m_pend) begin
        if (m_cnt == 1) begin
          m_done <= 1'b1; m_res <= m_hold; m_pend <= 1'b0;
        end else m_cnt <= m_cnt - 1;
      end
    end
  end

  // Spurious completions with a poisoned result while the block is idle or issuing.
  always @(negedge i_clk) inj_done <= inj_en && (gf.gf_start || !o_busy);
  assign gf.gf_done   = m_done | inj_done;
  assign gf.gf_result = m_done ? m_res : 32'hDEAD_BEEF;

  // ---- scoreboard ----
  typedef struct {
    logic [31:0] x3, y3;
    logic        inf3;
    int          lat, nops, scyc;
  } exp_t;
  exp_t sb[$];
  int   exp_ops[$];

  int          nstr = 0;
  logic        prev_st = 1'b0;
  bit          waiting = 1'b0;
  logic [65:0] wsig = '0;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      waiting = 1'b0; prev_st = 1'b0; nstr = 0;
    end else begin
      if (gf.gf_start) begin
        chk("strobe_back_to_back", 96'(prev_st), 96'(0));
        chk("strobe_during_wait", 96'(waiting), 96'(0));
        nstr++;
        if (exp_ops.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_strobe: got op %0d want none", gf.gf_op);
        end else chk("gf_op", 96'(gf.gf_op), 96'(exp_ops.pop_front()));
        wsig    = {gf.gf_op, gf.gf_in_0, gf.gf_in_1};
        waiting = 1'b1;
      end else if (waiting) begin
        chk("operand_stable", 96'({gf.gf_op, gf.gf_in_0, gf.gf_in_1}), 96'(wsig));
        if (m_done) waiting = 1'b0;
      end
      prev_st = gf.gf_start;
      if (o_done) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done want none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("inf3", 96'(o_inf3), 96'(e.inf3));
          if (!e.inf3) begin
            chk("x3", 96'(o_x3), 96'(e.x3));
            chk("y3", 96'(o_y3), 96'(e.y3));
          end
          chk("done_latency", 96'(cyc - e.scyc), 96'(e.lat));
          chk("strobe_count", 96'(nstr), 96'(e.nops));
          chk("busy_in_fin", 96'(o_busy), 96'(1));
        end
        nstr = 0;
      end
    end
  end

  // ---- stimulus ----
  task automatic start_txn(input longint x1, y1, x2, y2, a, input bit f1, f2, hold);
    exp_t   e;
    int     ops[$];
    longint lam;
    e.x3 = '0; e.y3 = '0; e.inf3 = 1'b0;
    if (f1) begin
      e.x3 = 32'(x2); e.y3 = 32'(y2); e.inf3 = f2;
    end else if (f2) begin
      e.x3 = 32'(x1); e.y3 = 32'(y1);
    end else if (x1 == x2 && (y1 != y2 || y1 == 0)) begin
      e.inf3 = 1'b1;
    end else begin
      if (x1 == x2) begin
        lam = mred((3 * x1 * x1 + a) * minv(2 * y1));
        ops = '{2, 0, 0, 0, 0, 3};
      end else begin
        lam = mred((y2 - y1) * minv(x2 - x1));
        ops = '{1, 1, 3};
      end
      ops = {ops, 2, 1, 1, 1, 2, 1};
      e.x3 = 32'(mred(lam * lam - x1 - x2));
      e.y3 = 32'(mred(lam * (x1 - longint'(e.x3)) - y1));
    end
    e.nops = ops.size();
    e.lat  = 2;
    foreach (ops[i]) e.lat += 1 + lat_of(ops[i]);
    @(negedge i_clk);
    e.scyc = cyc;
    sb.push_back(e);
    foreach (ops[i]) exp_ops.push_back(ops[i]);
    i_x1 = 32'(x1); i_y1 = 32'(y1); i_x2 = 32'(x2); i_y2 = 32'(y2); i_a = 32'(a);
    i_inf1 = f1; i_inf2 = f2; i_start = 1'b1;
    if (!hold) begin
      @(negedge i_clk);
      i_start = 1'b0;
      i_x1 = $urandom; i_y1 = $urandom; i_x2 = $urandom; i_y2 = $urandom; i_a = $urandom;
      i_inf1 = 1'($urandom); i_inf2 = 1'($urandom);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!o_done && k < 3000) begin
      @(negedge i_clk);
      k++;
    end
    chk("done_reached", 96'(k < 3000), 96'(1));
    i_start = 1'b0;
    @(negedge i_clk);
    chk("busy_after_fin", 96'(o_busy), 96'(0));
    chk("done_one_cycle", 96'(o_done), 96'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gf_start"}, 96'(gf.gf_start), 96'(0));
    chk({tag, "_done"},     96'(o_done), 96'(0));
    chk({tag, "_busy"},     96'(o_busy), 96'(0));
    chk({tag, "_x3"},       96'(o_x3), 96'(0));
    chk({tag, "_y3"},       96'(o_y3), 96'(0));
    chk({tag, "_inf3"},     96'(o_inf3), 96'(0));
    chk({tag, "_gf_op"},    96'(gf.gf_op), 96'(0));
    chk({tag, "_gf_in"},    96'({gf.gf_in_0, gf.gf_in_1}), 96'(0));
  endtask

  initial begin
    int n, k;
    repeat (2) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst_n = 1'b1;

    // addition, latency 1
    start_txn(5, 1, 6, 3, 2, 0, 0, 0);
    wait_done();
    chk("add_x3_const", 96'(o_x3), 96'(10));
    chk("add_y3_const", 96'(o_y3), 96'(6));

    // doubling, slow mult/div
    lat_md = 35; lat_as = 1;
    start_txn(5, 1, 5, 1, 2, 0, 0, 0);
    wait_done();
    chk("dbl_x3_const", 96'(o_x3), 96'(6));
    chk("dbl_y3_const", 96'(o_y3), 96'(3));

    // infinity cases
    start_txn(0, 0, 10, 6, 2, 1, 0, 0);
    wait_done();
    start_txn(5, 1, 5, 16, 2, 0, 0, 0);
    wait_done();

    // start held high, spurious completions in IDLE and ISSUE
    lat_md = 3; lat_as = 2; inj_en = 1'b1;
    repeat (3) @(negedge i_clk);
    start_txn(5, 1, 6, 3, 2, 0, 0, 1);
    wait_done();
    repeat (3) @(negedge i_clk);
    chk("no_restart_busy", 96'(o_busy), 96'(0));
    inj_en = 1'b0;
    lat_md = 1; lat_as = 1;

    // reset asserted in the ISSUE cycle of step 9 (4th strobe on the add path)
    start_txn(5, 1, 6, 3, 2, 0, 0, 0);
    n = (gf.gf_start) ? 1 : 0;
    k = 0;
    while (n < 4 && k < 200) begin
      @(negedge i_clk);
      if (gf.gf_start) n++;
      k++;
    end
    chk("reached_step9", 96'(n), 96'(4));
    #2 i_rst_n = 1'b0;
    #1 chk_all_zero("abort");
    sb.delete();
    exp_ops.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    start_txn(5, 1, 6, 3, 2, 0, 0, 0);
    wait_done();
    chk("post_reset_x3", 96'(o_x3), 96'(10));
    chk("post_reset_y3", 96'(o_y3), 96'(6));

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      longint x1, y1, x2, y2, a;
      bit f1, f2;
      int sel;
      lat_md = $urandom_range(1, 6);
      lat_as = $urandom_range(1, 3);
      inj_en = 1'($urandom);
      x1 = $urandom_range(0, 16); y1 = $urandom_range(0, 16);
      x2 = $urandom_range(0, 16); y2 = $urandom_range(0, 16);
      a  = $urandom_range(0, 16);
      f1 = 1'b0; f2 = 1'b0;
      sel = $urandom_range(0, 9);
      case (sel)
        0: f1 = 1'b1;
        1: f2 = 1'b1;
        2: begin x2 = x1; y2 = y1; end
        3: begin x2 = x1; y2 = mred(-y1); end
        4: begin x2 = x1; y1 = 0; y2 = 0; end
        default: ;
      endcase
      start_txn(x1, y1, x2, y2, a, f1, f2, 1'($urandom));
      wait_done();
    end
    inj_en = 1'b0;
    chk("sb_drained", 96'(sb.size() + exp_ops.size()), 96'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
